// File: rtl/msk_aes_share_loader_if.sv
// Handshake and data bundle between the masked word stream, the share loader
// and the round-based AES core.
interface msk_aes_share_loader_if #(
  parameter int d = 2,
  parameter int W = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [W*d-1:0]     in_data;
  logic               in_last;
  logic               err;
  logic               aes_valid;
  logic               aes_ready;
  logic [128*d-1:0]   sh_plaintext;
  logic [128*d-1:0]   sh_key;
  logic               busy;

  modport master (
    output in_valid, in_data, in_last, aes_ready,
    input  in_ready, err, aes_valid, sh_plaintext, sh_key, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, aes_ready,
    output in_ready, err, aes_valid, sh_plaintext, sh_key, busy
  );
endinterface

// File: rtl/msk_aes_share_loader.sv
// Assembles a stream of masked W-bit words (plaintext then key, MS word first)
// into full d-share sharings and hands them to the AES core via valid/ready.
module msk_aes_share_loader #(
  parameter int d = 2,
  parameter int W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  msk_aes_share_loader_if.slave   bus
);

  localparam int NW    = 128 / W;
  localparam int NSLOT = 2 * NW;
  localparam int CW    = $clog2(NSLOT);
  localparam int SW    = W * d;
  localparam logic [CW-1:0] LAST_CNT = CW'(NSLOT - 1);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            err_reg, err_next;
  logic            accept;
  logic            final_slot;

  assign accept     = (state_reg == ST_LOAD) && bus.in_valid;
  assign final_slot = (cnt_reg == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_LOAD;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = 1'b0;
    case (state_reg)
      ST_LOAD: begin
        if (accept) begin
          // in_last must coincide exactly with the final key word
          if (bus.in_last != final_slot) begin
            err_next = 1'b1;
            cnt_next = '0;
          end else if (final_slot) begin
            cnt_next   = '0;
            state_next = ST_FULL;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      ST_FULL: begin
        if (bus.aes_ready) begin
          state_next = ST_LOAD;
        end
      end
      default: begin
        state_next = ST_LOAD;
        cnt_next   = '0;
      end
    endcase
  end

  // One storage slot per word position; shares are copied verbatim so no
  // bit of any share is ever combined with another share of the same bit.
  genvar gi;
  generate
    for (gi = 0; gi < NW; gi++) begin : g_slot
      localparam int HI = (128 - W * gi) * d - 1;
      logic [SW-1:0] pt_w_reg;
      logic [SW-1:0] key_w_reg;

      always_ff @(posedge clk) begin
        if (accept && (cnt_reg == CW'(gi))) begin
          pt_w_reg <= bus.in_data;
        end
        if (accept && (cnt_reg == CW'(NW + gi))) begin
          key_w_reg <= bus.in_data;
        end
      end

      assign bus.sh_plaintext[HI -: SW] = pt_w_reg;
      assign bus.sh_key[HI -: SW]       = key_w_reg;
    end
  endgenerate

  assign bus.in_ready  = (state_reg == ST_LOAD);
  assign bus.aes_valid = (state_reg == ST_FULL);
  assign bus.err       = err_reg;
  assign bus.busy      = (cnt_reg != '0) || (state_reg == ST_FULL);

endmodule
